// File: rtl/spi_pwm_ctrl.sv
// spi_pwm_ctrl: register-write front end for a bank of edge-aligned PWM channels.
//
// Command words arrive from the SPI receive stage (SCK domain). The word-complete
// flag is synchronised into CLK. Each word is an address/value write into staging
// registers. Staging period/duties are copied to the active set at period wrap, or
// on every cycle while disabled, so a PWM cycle never sees a half-applied update.
//
// Ports:
//   CLK          system clock
//   rst_n        asynchronous active-low reset
//   spi_data     16-bit received word {addr[3:0], value[11:0]} (SCK domain, quasi-static)
//   spi_valid    word-complete flag (SCK domain, asynchronous to CLK)
//   pwm_out      PWM outputs, bit i = channel i
//   period_wrap  one-cycle pulse aligned with the last output cycle of each period
//   cmd_ack      one-cycle pulse when a mapped word is decoded
//   cmd_err      one-cycle pulse when a word carries an unmapped address
//   pwm_en       current global enable
module spi_pwm_ctrl #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [11:0] RESET_PERIOD = 12'hFFF
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [15:0]       spi_data,
  input  logic              spi_valid,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_wrap,
  output logic              cmd_ack,
  output logic              cmd_err,
  output logic              pwm_en
);

  localparam int unsigned CW = 12;
  localparam int unsigned AW = 4;
  localparam logic [AW-1:0] ADDR_CTRL   = 4'd0;
  localparam logic [AW-1:0] ADDR_PERIOD = 4'd1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] value;
  } cmd_t;

  // Synchroniser and arrival detection
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   arrive_c;

  // Decode
  cmd_t              cmd_c;
  logic              wr_ctrl_c;
  logic              wr_period_c;
  logic [NUM_CH-1:0] wr_duty_c;
  logic              unmapped_c;

  // Register file
  logic                       en_q, en_d;
  logic [CW-1:0]              period_stg_q, period_stg_d;
  logic [CW-1:0]              period_act_q, period_act_d;
  logic [NUM_CH-1:0][CW-1:0]  duty_stg_q, duty_stg_d;
  logic [NUM_CH-1:0][CW-1:0]  duty_act_q, duty_act_d;

  // Counter
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_c;
  logic          load_c;
  logic          clr_c;

  // Registered outputs
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              wrap_q, wrap_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  // Synchroniser chain; arrival is a rising edge at the end of the chain.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], spi_valid};
    hist_d   = sync_q[SYNC_STAGES-1];
    arrive_c = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // Chain and history reset high: a flag still high when reset releases is
  // treated as already seen, so an interrupted word is never accepted late.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // Address decode of the word sampled on the arrival cycle.
  always_comb begin
    cmd_c       = cmd_t'(spi_data);
    wr_ctrl_c   = arrive_c && (cmd_c.addr == ADDR_CTRL);
    wr_period_c = arrive_c && (cmd_c.addr == ADDR_PERIOD);
    wr_duty_c   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_duty_c[i] = arrive_c && (cmd_c.addr == AW'(i + 2));
    end
    unmapped_c  = arrive_c && !wr_ctrl_c && !wr_period_c && (wr_duty_c == '0);
  end

  // Staging registers and enable.
  always_comb begin
    en_d         = en_q;
    period_stg_d = period_stg_q;
    duty_stg_d   = duty_stg_q;
    if (wr_ctrl_c) begin
      en_d = cmd_c.value[0];
    end
    if (wr_period_c) begin
      period_stg_d = cmd_c.value;
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr_duty_c[i]) begin
        duty_stg_d[i] = cmd_c.value;
      end
    end
  end

  // Period counter and shadow load. Staging is read from the flops, so a write
  // landing on the wrap edge is picked up only at the following wrap.
  always_comb begin
    wrap_c       = en_q && (cnt_q == period_act_q);
    load_c       = !en_q || wrap_c;
    // CTRL clear bit, or a disable, restarts the count from zero.
    clr_c        = wr_ctrl_c && (cmd_c.value[1] || !cmd_c.value[0]);
    period_act_d = load_c ? period_stg_q : period_act_q;
    duty_act_d   = load_c ? duty_stg_q : duty_act_q;
    if (!en_q || wrap_c || clr_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      period_stg_q <= RESET_PERIOD;
      period_act_q <= RESET_PERIOD;
      duty_stg_q   <= '0;
      duty_act_q   <= '0;
      cnt_q        <= '0;
    end else begin
      en_q         <= en_d;
      period_stg_q <= period_stg_d;
      period_act_q <= period_act_d;
      duty_stg_q   <= duty_stg_d;
      duty_act_q   <= duty_act_d;
      cnt_q        <= cnt_d;
    end
  end

  // Output stage: compare against active duties, one cycle behind the counter.
  always_comb begin
    pwm_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = en_q && (cnt_q < duty_act_q[i]);
    end
    wrap_d = wrap_c;
    ack_d  = arrive_c && !unmapped_c;
    err_d  = unmapped_c;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q  <= '0;
      wrap_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pwm_q  <= pwm_d;
      wrap_q <= wrap_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_wrap = wrap_q;
  assign cmd_ack     = ack_q;
  assign cmd_err     = err_q;
  assign pwm_en      = en_q;

endmodule

// File: tb/tb_spi_pwm_ctrl.sv
// Testbench for spi_pwm_ctrl: SPI word driver, response scoreboard, and
// per-period PWM measurements compared against hand-derived expectations.
module tb_spi_pwm_ctrl;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned LAT         = SYNC_STAGES + 1;
  localparam int unsigned HOLD        = SYNC_STAGES + 2;

  logic              CLK = 1'b0;
  logic              rst_n;
  logic [15:0]       spi_data;
  logic              spi_valid;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_wrap;
  logic              cmd_ack;
  logic              cmd_err;
  logic              pwm_en;

  spi_pwm_ctrl #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_PERIOD(12'hFFF)
  ) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .spi_data   (spi_data),
    .spi_valid  (spi_valid),
    .pwm_out    (pwm_out),
    .period_wrap(period_wrap),
    .cmd_ack    (cmd_ack),
    .cmd_err    (cmd_err),
    .pwm_en     (pwm_en)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    bit          rsp;
    bit          ack;
    bit          err;
    int unsigned hold;
  } tx_t;

  typedef struct {
    int unsigned cyc;
    bit          ack;
    bit          err;
  } rsp_t;

  tx_t  tx_q[$];
  rsp_t sb_q[$];
  bit   drv_busy = 1'b0;

  int unsigned last_ack_cyc     = 0;
  bit          last_ack_on_wrap = 1'b0;

  int m_len[8];
  int m_hi[8][NUM_CH];
  int e2[3] = '{3, 7, 7};
  int act;

  // SPI stage model: one word per queue entry, expected response pushed on drive.
  initial begin : driver
    tx_t t;
    spi_valid = 1'b0;
    spi_data  = '0;
    forever begin
      @(negedge CLK);
      if (tx_q.size() != 0) begin
        t = tx_q.pop_front();
        drv_busy  = 1'b1;
        spi_data  = t.data;
        spi_valid = 1'b1;
        if (t.rsp) sb_q.push_back('{cyc + LAT, t.ack, t.err});
        repeat (t.hold) @(negedge CLK);
        spi_valid = 1'b0;
        repeat (HOLD) @(negedge CLK);
        drv_busy = 1'b0;
      end
    end
  end

  // Response monitor: every ack/err must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (rst_n && (cmd_ack || cmd_err)) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 32'({cmd_ack, cmd_err}), 32'd0);
      end else begin
        chk("rsp_latency", cyc, sb_q[0].cyc);
        chk("rsp_ack", 32'(cmd_ack), 32'(sb_q[0].ack));
        chk("rsp_err", 32'(cmd_err), 32'(sb_q[0].err));
        sb_q.delete(0);
      end
      last_ack_cyc     <= cyc;
      last_ack_on_wrap <= period_wrap;
    end else if (rst_n && sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
      chk("rsp_missing", cyc, sb_q[0].cyc);
      sb_q.delete(0);
    end
  end

  task automatic send(input logic [15:0] d, input bit is_err);
    tx_t t;
    t.data = d;
    t.rsp  = 1'b1;
    t.ack  = !is_err;
    t.err  = is_err;
    t.hold = HOLD;
    tx_q.push_back(t);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((tx_q.size() != 0 || drv_busy) && i < 400) begin
      @(negedge CLK);
      i++;
    end
    if (tx_q.size() != 0 || drv_busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_wrap();
    int i;
    i = 0;
    do begin
      @(negedge CLK);
      i++;
    end while (!period_wrap && i < 100);
    if (!period_wrap) chk("wrap_timeout", 32'd0, 32'd1);
  endtask

  // Each measured period runs up to and including the cycle showing period_wrap.
  task automatic measure(input int n, input bit sync_first);
    if (sync_first) wait_wrap();
    for (int p = 0; p < n; p++) begin
      m_len[p] = 0;
      for (int ch = 0; ch < NUM_CH; ch++) m_hi[p][ch] = 0;
      do begin
        @(negedge CLK);
        m_len[p]++;
        for (int ch = 0; ch < NUM_CH; ch++) m_hi[p][ch] += int'(pwm_out[ch]);
      end while (!period_wrap && m_len[p] < 300);
      if (!period_wrap) chk("period_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("rst_period_wrap", 32'(period_wrap), 32'd0);
    chk("rst_cmd_ack", 32'(cmd_ack), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("rst_pwm_en", 32'(pwm_en), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge CLK);
    chk("idle_no_wrap", 32'(period_wrap), 32'd0);

    // 1: period 9, duty0 3, then enable
    send(16'h1009, 1'b0);
    send(16'h2003, 1'b0);
    send(16'h0001, 1'b0);
    wait_idle();
    chk("t1_en", 32'(pwm_en), 32'd1);
    measure(3, 1'b1);
    for (int p = 0; p < 3; p++) begin
      chk("t1_len", 32'(m_len[p]), 32'd10);
      chk("t1_hi0", 32'(m_hi[p][0]), 32'd3);
    end

    // 2: duty change mid-period applies after the next wrap
    wait_wrap();
    @(posedge CLK);
    #1 send(16'h2007, 1'b0);
    measure(3, 1'b0);
    for (int p = 0; p < 3; p++) begin
      chk("t2_len", 32'(m_len[p]), 32'd10);
      chk("t2_hi0", 32'(m_hi[p][0]), 32'(e2[p]));
    end
    wait_idle();

    // 3: duty 0, duty > period, period 0
    send(16'h3000, 1'b0);
    send(16'h400A, 1'b0);
    wait_idle();
    measure(2, 1'b1);
    for (int p = 0; p < 2; p++) begin
      chk("t3_len", 32'(m_len[p]), 32'd10);
      chk("t3_hi0", 32'(m_hi[p][0]), 32'd7);
      chk("t3_hi1_zero", 32'(m_hi[p][1]), 32'd0);
      chk("t3_hi2_full", 32'(m_hi[p][2]), 32'd10);
    end
    send(16'h1000, 1'b0);
    send(16'h5001, 1'b0);
    wait_idle();
    measure(4, 1'b1);
    for (int p = 0; p < 4; p++) begin
      chk("t3_p0_len", 32'(m_len[p]), 32'd1);
      chk("t3_p0_hi1", 32'(m_hi[p][1]), 32'd0);
      chk("t3_p0_hi2", 32'(m_hi[p][2]), 32'd1);
      chk("t3_p0_hi3", 32'(m_hi[p][3]), 32'd1);
    end
    send(16'h1009, 1'b0);
    wait_idle();

    // 4: unmapped address
    send(16'hF123, 1'b1);
    wait_idle();
    chk("t4_en", 32'(pwm_en), 32'd1);
    measure(2, 1'b1);
    for (int p = 0; p < 2; p++) begin
      chk("t4_len", 32'(m_len[p]), 32'd10);
      chk("t4_hi0", 32'(m_hi[p][0]), 32'd7);
      chk("t4_hi1", 32'(m_hi[p][1]), 32'd0);
      chk("t4_hi2", 32'(m_hi[p][2]), 32'd10);
      chk("t4_hi3", 32'(m_hi[p][3]), 32'd1);
    end

    // 5a: duty write landing on the wrap cycle is deferred one period
    wait_idle();
    wait_wrap();
    repeat (10 - LAT - 1) @(negedge CLK);
    @(posedge CLK);
    #1 send(16'h2002, 1'b0);
    measure(2, 1'b1);
    chk("t5_ack_on_wrap", 32'(last_ack_on_wrap), 32'd1);
    chk("t5_hi0_deferred", 32'(m_hi[0][0]), 32'd7);
    chk("t5_hi0_applied", 32'(m_hi[1][0]), 32'd2);

    // 5b: CTRL clear mid-period restarts the count
    wait_idle();
    wait_wrap();
    @(posedge CLK);
    #1 send(16'h0003, 1'b0);
    measure(1, 1'b0);
    chk("t5_restart_len", 32'(m_len[0]), 32'(LAT + 11));
    chk("t5_restart_hi0", 32'(m_hi[0][0]), 32'd4);
    chk("t5_restart_gap", cyc - last_ack_cyc, 32'd10);

    // 5c: disable stops all activity, re-enable resumes
    wait_idle();
    send(16'h0000, 1'b0);
    wait_idle();
    chk("t5_dis_en", 32'(pwm_en), 32'd0);
    act = 0;
    repeat (12) begin
      @(negedge CLK);
      act += int'(period_wrap) + int'(|pwm_out);
    end
    chk("t5_dis_activity", 32'(act), 32'd0);
    send(16'h0001, 1'b0);
    wait_idle();
    chk("t5_reen_en", 32'(pwm_en), 32'd1);

    // 6: reset during output with a word in the synchroniser
    wait_wrap();
    @(posedge CLK);
    #1 tx_q.push_back('{16'h2005, 1'b0, 1'b0, 1'b0, 32'd20});
    @(negedge CLK);
    @(negedge CLK);
    chk("t6_pwm_before_rst", 32'(pwm_out[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("t6_rst_pwm_en", 32'(pwm_en), 32'd0);
    chk("t6_rst_wrap", 32'(period_wrap), 32'd0);
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    wait_idle();
    repeat (10) @(negedge CLK);
    chk("t6_post_pwm_en", 32'(pwm_en), 32'd0);
    chk("t6_post_pwm_out", 32'(pwm_out), 32'd0);
    send(16'h0001, 1'b0);
    wait_idle();
    chk("t6_post_enable", 32'(pwm_en), 32'd1);
    repeat (4) @(negedge CLK);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_pwm_ctrl.md
Name: spi_pwm_ctrl

Overview:
- Consumes 16-bit command words from the SPI receive stage (`data_out` / `rx_valid`, both in the SCK domain).
- Synchronises word arrival into the system clock domain and decodes each word as an address/value register write.
- Drives NUM_CH edge-aligned PWM outputs from a shared period counter.
- Duty and period updates are double-buffered and take effect only at period wrap, so no glitched PWM cycles occur.

Parameters:
- NUM_CH, 4, number of PWM channels; legal range 1..14.
- SYNC_STAGES, 2, flops in the `spi_valid` synchroniser; minimum 2.
- RESET_PERIOD, 12'hFFF, reset value of the period register.

Ports:
- CLK  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- spi_data  input  16  received word from the SPI stage (SCK domain).
- spi_valid  input  1  word-complete flag from the SPI stage (SCK domain, asynchronous to CLK).
- pwm_out  output  NUM_CH  PWM outputs, bit i = channel i.
- period_wrap  output  1  one-CLK pulse at the last count of each PWM period.
- cmd_ack  output  1  one-CLK pulse when a word is accepted and decoded.
- cmd_err  output  1  one-CLK pulse when the decoded address is unmapped.
- pwm_en  output  1  current global enable state.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on rst_n. All state is cleared immediately on rst_n=0 and released synchronously to CLK.
- Reset values:
  - pwm_out=0, period_wrap=0, cmd_ack=0, cmd_err=0, pwm_en=0.
  - Counter=0.
  - Staging and active period=RESET_PERIOD.
  - All staging and active duties=0.
- CDC:
  - spi_valid passes through SYNC_STAGES flops plus one history flop.
  - A rising edge (sync=1, history=0) is an arrival event.
  - spi_data is not synchronised. It is sampled on the arrival-event cycle and is stable then, because the SPI stage changes it only at the next word completion.
  - Input constraint: spi_valid high and low widths each ≥ SYNC_STAGES+1 CLK periods. Narrower pulses may be lost; no other failure mode is permitted.
- Decode latency: the write to the staging register, and cmd_ack/cmd_err, occur exactly SYNC_STAGES+1 CLK cycles after spi_valid rises (pulse-aligned with the sampled word).
- Word format: addr=spi_data[15:12], value=spi_data[11:0].
  - addr 0, CTRL:
    - value[0] sets the global enable.
    - value[1]=1 clears the counter to 0 on the decode cycle. This bit is self-clearing and not stored.
    - value[11:2] are ignored.
  - addr 1, PERIOD: staging period = value.
  - addr 2..NUM_CH+1, DUTY[addr-2]: staging duty = value.
  - Any other addr: no register change; cmd_err=1 and cmd_ack=0 for one cycle.
- Counter:
  - 12-bit. When enabled it counts 0..active_period, then returns to 0.
  - period_wrap=1 on the cycle in which counter==active_period and enable=1.
  - active_period=0: counter stays 0 and period_wrap is high every enabled cycle.
- Shadow load:
  - On the wrap cycle, active period and all active duties load from staging. The counter goes to 0 in the same edge.
  - A staging write on the wrap cycle is not captured by that load; it applies at the next wrap.
  - While enable=0, active registers load from staging every cycle.
- Outputs:
  - pwm_out[i] = enable AND (counter < active_duty[i]). It is registered, so 1 CLK behind the counter.
  - duty=0: output always low.
  - duty > active_period: output always high.
  - Output period = active_period+1 CLK cycles.
- Enable transitions:
  - enable 1→0: counter forced to 0; pwm_out goes 0 on the next cycle.
  - enable 0→1: counting starts from 0 on the following cycle.
- Soft reset with an enable write: a CTRL write with value[0]=1 and value[1]=1 enables the block and starts from count 0.
- Reset mid-operation: all outputs drop immediately on rst_n=0. A word in flight in the synchroniser is discarded.

Test Plan:
1. After reset, write CTRL=0x001, PERIOD=9, DUTY0=3 -> pwm_out[0] high 3 of every 10 CLK; period_wrap pulses every 10 CLK; cmd_ack pulses 3 CLK after each spi_valid rise.
2. Running at period 9 / duty 3, write DUTY0=7 mid-period -> current period completes at 3-high; every period after the next period_wrap shows 7-high.
3. Duty edge cases: DUTY1=0 -> pwm_out[1] constantly 0. DUTY2=10 with PERIOD=9 -> pwm_out[2] constantly 1. PERIOD=0 with DUTY3=1 -> pwm_out[3] constantly 1 and period_wrap high every cycle.
4. Word 0xF123 (unmapped address) -> cmd_err pulse for one cycle, no cmd_ack, all register readback via PWM behaviour unchanged.
5. Timing the staging write to land on the period_wrap cycle -> new duty takes effect one period later. CTRL=0x003 mid-period -> counter restarts at 0 the next cycle.
6. Assert rst_n low during active PWM with a spi_valid pulse in flight -> pwm_out=0 immediately; no cmd_ack after reset release; pwm_en=0.
